// File: rtl/rx_est_pkg.sv
// ============================================================================
//  Module      : rx_est_pkg
//  Description : Shared state encoding and width helpers for the receive-side
//                noise estimator (top rx_noise_estimator, sub rx_err_power).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_est_pkg;

    // Measurement controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } est_state_t;

    // Last value of the flush counter: two pipeline stages plus the
    // accumulate edge must settle before the result is sampled.
    localparam logic [1:0] c_flush_last = 2'd2;

    // Slicer error width: one extra bit so In - d never wraps
    function automatic int err_width(input int dw);
        return dw + 1;
    endfunction

    // Width of a single unsigned square
    function automatic int sq_width(input int dw);
        return 2 * dw + 2;
    endfunction

    // Block accumulator width: room for 2^log2_n sums without overflow
    function automatic int acc_width(input int pow_w, input int log2_n);
        return pow_w + log2_n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_err_power.sv
// ============================================================================
//  Module      : rx_err_power
//  Description : QPSK slicer, slicer error and squaring pipeline (S1-S2).
//                Produces e_I^2, e_Q^2, I^2, Q^2 with a valid tag that
//                follows only accepted samples.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_err_power
    import rx_est_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int A_REF  = 10000,
    localparam int c_err_w = err_width(DWIDTH),
    localparam int c_sq_w  = sq_width(DWIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] In_I,
    input  logic signed [DWIDTH-1:0] In_Q,
    output logic                     sq_valid,
    output logic        [c_sq_w-1:0] e_sq_i,
    output logic        [c_sq_w-1:0] e_sq_q,
    output logic        [c_sq_w-1:0] s_sq_i,
    output logic        [c_sq_w-1:0] s_sq_q
);

    localparam logic signed [c_err_w-1:0] c_a_ref = c_err_w'(A_REF);

    logic signed [c_err_w-1:0] w_ext_i, w_ext_q;
    logic signed [c_err_w-1:0] w_d_i, w_d_q;
    logic signed [c_err_w-1:0] w_e_i, w_e_q;

    // Slicer: zero is treated as positive and maps to +A_REF
    assign w_ext_i = {In_I[DWIDTH-1], In_I};
    assign w_ext_q = {In_Q[DWIDTH-1], In_Q};
    assign w_d_i   = In_I[DWIDTH-1] ? -c_a_ref : c_a_ref;
    assign w_d_q   = In_Q[DWIDTH-1] ? -c_a_ref : c_a_ref;
    assign w_e_i   = w_ext_i - w_d_i;
    assign w_e_q   = w_ext_q - w_d_q;

    logic                      r_v1;
    logic signed [c_err_w-1:0] r_e_i, r_e_q;
    logic signed [DWIDTH-1:0]  r_x_i, r_x_q;

    // S1: capture error and raw sample for accepted inputs only
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_e_i <= '0;
            r_e_q <= '0;
            r_x_i <= '0;
            r_x_q <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_e_i <= w_e_i;
                r_e_q <= w_e_q;
                r_x_i <= In_I;
                r_x_q <= In_Q;
            end
        end
    end

    logic signed [c_sq_w-1:0] w_xe_i, w_xe_q, w_xs_i, w_xs_q;
    logic signed [c_sq_w-1:0] w_pe_i, w_pe_q, w_ps_i, w_ps_q;

    // Sign-extend to the square width so the products are full precision
    assign w_xe_i = {{(c_sq_w-c_err_w){r_e_i[c_err_w-1]}}, r_e_i};
    assign w_xe_q = {{(c_sq_w-c_err_w){r_e_q[c_err_w-1]}}, r_e_q};
    assign w_xs_i = {{(c_sq_w-DWIDTH){r_x_i[DWIDTH-1]}}, r_x_i};
    assign w_xs_q = {{(c_sq_w-DWIDTH){r_x_q[DWIDTH-1]}}, r_x_q};
    assign w_pe_i = w_xe_i * w_xe_i;
    assign w_pe_q = w_xe_q * w_xe_q;
    assign w_ps_i = w_xs_i * w_xs_i;
    assign w_ps_q = w_xs_q * w_xs_q;

    // S2: register squares (always non-negative, so stored unsigned)
    always_ff @(posedge clk) begin
        if (!rst) begin
            sq_valid <= 1'b0;
            e_sq_i   <= '0;
            e_sq_q   <= '0;
            s_sq_i   <= '0;
            s_sq_q   <= '0;
        end else begin
            sq_valid <= r_v1;
            if (r_v1) begin
                e_sq_i <= $unsigned(w_pe_i);
                e_sq_q <= $unsigned(w_pe_q);
                s_sq_i <= $unsigned(w_ps_i);
                s_sq_q <= $unsigned(w_ps_q);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_noise_estimator.sv
// ============================================================================
//  Module      : rx_noise_estimator
//  Description : Measures mean slicer-error power and mean signal power of
//                received QPSK samples over blocks of 2^LOG2_N samples.
//                Optional macro RX_NOISE_SATCOUNT_EN enables the full-scale
//                sample counter on sat_count (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_noise_estimator
    import rx_est_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int LOG2_N = 6,
    parameter int A_REF  = 10000,
    parameter int POW_W  = 2 * DWIDTH + 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cont,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] In_I,
    input  logic signed [DWIDTH-1:0] In_Q,
    output logic                     busy,
    output logic                     est_valid,
    output logic        [POW_W-1:0]  noise_pow,
    output logic        [POW_W-1:0]  sig_pow,
    output logic        [LOG2_N:0]   sat_count
);

    localparam int c_sq_w  = sq_width(DWIDTH);
    localparam int c_acc_w = acc_width(POW_W, LOG2_N);

    est_state_t r_state, w_next;
    logic       w_clear, w_load, w_accept;

    logic [LOG2_N-1:0]  r_cnt;
    logic [1:0]         r_flush;
    logic [c_acc_w-1:0] r_acc_e, r_acc_s;

    logic              w_sq_valid;
    logic [c_sq_w-1:0] w_e_sq_i, w_e_sq_q, w_s_sq_i, w_s_sq_q;
    logic [POW_W-1:0]  w_e_sum, w_s_sum;

    // Samples are only taken while a block is being collected
    assign w_accept = in_valid && (r_state == ST_ACCUM);

    rx_err_power #(
        .DWIDTH (DWIDTH),
        .A_REF  (A_REF)
    ) u_err_power (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w_accept),
        .In_I     (In_I),
        .In_Q     (In_Q),
        .sq_valid (w_sq_valid),
        .e_sq_i   (w_e_sq_i),
        .e_sq_q   (w_e_sq_q),
        .s_sq_i   (w_s_sq_i),
        .s_sq_q   (w_s_sq_q)
    );

    // S3 adder: I+Q power of one sample
    assign w_e_sum = POW_W'(w_e_sq_i) + POW_W'(w_e_sq_q);
    assign w_s_sum = POW_W'(w_s_sq_i) + POW_W'(w_s_sq_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, block clear and result load decode
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next  = ST_ACCUM;
                    w_clear = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (w_accept && (&r_cnt)) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flush == c_flush_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_load = 1'b1;
                if (cont) begin
                    w_next  = ST_ACCUM;
                    w_clear = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Sample counter, flush timer and block accumulators
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_flush <= '0;
            r_acc_e <= '0;
            r_acc_s <= '0;
        end else begin
            r_flush <= (r_state == ST_FLUSH) ? r_flush + 2'd1 : 2'd0;
            if (w_clear) begin
                r_cnt   <= '0;
                r_acc_e <= '0;
                r_acc_s <= '0;
            end else begin
                if (w_accept) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_sq_valid) begin
                    r_acc_e <= r_acc_e + c_acc_w'(w_e_sum);
                    r_acc_s <= r_acc_s + c_acc_w'(w_s_sum);
                end
            end
        end
    end

    // Result registers: mean = accumulator / N, held until the next block
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= 1'b0;
            est_valid <= 1'b0;
            noise_pow <= '0;
            sig_pow   <= '0;
        end else begin
            busy      <= (w_next != ST_IDLE);
            est_valid <= w_load;
            if (w_load) begin
                noise_pow <= r_acc_e[c_acc_w-1:LOG2_N];
                sig_pow   <= r_acc_s[c_acc_w-1:LOG2_N];
            end
        end
    end

`ifdef RX_NOISE_SATCOUNT_EN
    localparam logic signed [DWIDTH-1:0] c_pos_fs = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] c_neg_fs = {1'b1, {(DWIDTH-1){1'b0}}};

    logic            w_sat;
    logic [LOG2_N:0] r_sat_acc;

    assign w_sat = (In_I == c_pos_fs) || (In_I == c_neg_fs) ||
                   (In_Q == c_pos_fs) || (In_Q == c_neg_fs);

    // Full-scale sample counter, published together with the powers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sat_acc <= '0;
            sat_count <= '0;
        end else begin
            if (w_clear) begin
                r_sat_acc <= '0;
            end else if (w_accept && w_sat) begin
                r_sat_acc <= r_sat_acc + (LOG2_N+1)'(1);
            end
            if (w_load) begin
                sat_count <= r_sat_acc;
            end
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_noise_estimator.sv
// ============================================================================
//  Module      : tb_rx_noise_estimator
//  Description : Scoreboard bench for rx_noise_estimator with directed blocks
//                and hand-computed expected powers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_noise_estimator;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               cont;
    logic               in_valid;
    logic signed [15:0] In_I;
    logic signed [15:0] In_Q;
    logic               busy;
    logic               est_valid;
    logic [34:0]        noise_pow;
    logic [34:0]        sig_pow;
    logic [6:0]         sat_count;

`ifdef RX_NOISE_SATCOUNT_EN
    localparam int c_sat_full = 64;
`else
    localparam int c_sat_full = 0;
`endif

    typedef struct {
        logic [34:0] noise;
        logic [34:0] sig;
        logic [6:0]  sat;
        logic        busy;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    rx_noise_estimator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .in_valid  (in_valid),
        .In_I      (In_I),
        .In_Q      (In_Q),
        .busy      (busy),
        .est_valid (est_valid),
        .noise_pow (noise_pow),
        .sig_pow   (sig_pow),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && est_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_est_valid: got est_valid=1, required 0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("noise_pow", 64'(noise_pow), 64'(e.noise));
                chk("sig_pow",   64'(sig_pow),   64'(e.sig));
                chk("sat_count", 64'(sat_count), 64'(e.sat));
                chk("busy_at_result", 64'(busy), 64'(e.busy));
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic send_block(input int vi, input int vq, input bit do_start,
                              input bit gaps, input bit mid_start, input bit cont_val,
                              input logic [34:0] en, input logic [34:0] es,
                              input int esat, input bit ebusy);
        int   last_cyc;
        exp_t e;
        last_cyc = 0;
        if (do_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            start    = (mid_start && i == 20);
            if (i == 10) cont = cont_val;
            in_valid = 1'b1;
            In_I     = 16'(vi);
            In_Q     = 16'(vq);
            if (i == 63) last_cyc = cyc;
            if (gaps && i != 63) begin
                @(negedge clk);
                start    = 1'b0;
                in_valid = 1'b0;
                In_I     = 16'sh7fff;
                In_Q     = 16'sh1234;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        e.noise  = en;
        e.sig    = es;
        e.sat    = 7'(esat);
        e.busy   = ebusy;
        e.cyc    = last_cyc + 5;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL result_timeout: got %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cont = 1'b0; in_valid = 1'b0;
        In_I = '0; In_Q = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_est_valid", 64'(est_valid), 64'd0);
        chk("rst_noise_pow", 64'(noise_pow), 64'd0);
        chk("rst_sig_pow",   64'(sig_pow),   64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Clean constellation point
        send_block(10000, -10000, 1, 0, 0, 0, 35'd0, 35'd200000000, 0, 0);
        wait_idle();
        // Fixed offset of +100 on both axes
        send_block(10100, -9900, 1, 0, 0, 0, 35'd20000, 35'd200020000, 0, 0);
        wait_idle();
        // Zero slices to +A_REF
        send_block(0, 0, 1, 0, 0, 0, 35'd200000000, 35'd0, 0, 0);
        wait_idle();
        // Negative full scale
        send_block(-32768, -32768, 1, 0, 0, 0, 35'd1036763648, 35'd2147483648, c_sat_full, 0);
        wait_idle();
        // in_valid gaps give the gapless result
        send_block(10000, -10000, 1, 1, 0, 0, 35'd0, 35'd200000000, 0, 0);
        wait_idle();
        // start mid-block is ignored
        send_block(10100, -9900, 1, 0, 1, 0, 35'd20000, 35'd200020000, 0, 0);
        wait_idle();

        // Continuous mode: two back-to-back blocks, busy stays high
        cont = 1'b1;
        send_block(10000, -10000, 1, 0, 0, 1, 35'd0, 35'd200000000, 0, 1);
        repeat (3) @(negedge clk);
        send_block(10100, -9900, 0, 0, 0, 0, 35'd20000, 35'd200020000, 0, 0);
        wait_idle();
        cont = 1'b0;

        // Reset in the middle of a block discards it
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; In_I = 16'sd10000; In_Q = -16'sd10000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_est_valid", 64'(est_valid), 64'd0);
        chk("midrst_noise_pow", 64'(noise_pow), 64'd0);
        chk("midrst_sig_pow",   64'(sig_pow),   64'd0);
        chk("midrst_sat_count", 64'(sat_count), 64'd0);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_idle_busy", 64'(busy), 64'd0);
        send_block(10000, -10000, 1, 0, 0, 0, 35'd0, 35'd200000000, 0, 0);
        wait_idle();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no completion, required finish before %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire

// File: doc/rx_noise_estimator.md
Name: rx_noise_estimator

Overview:
- Receiver-side counterpart of the noise-injecting channel: measures the noise it added.
- Takes received QPSK I/Q samples, slices them to ideal points ±A_REF, and computes per-sample error power and signal power.
- Averages both over a block of 2^LOG2_N accepted samples and reports the results, so the bench or a later SNR/AGC stage can compare measured noise power against the programmed sigma_scale.

Parameters:
- DWIDTH, 16, sample width (signed I/Q).
- LOG2_N, 6, log2 of the averaging block length (N = 64).
- A_REF, 10000, ideal constellation amplitude per axis.
- POW_W, 2*DWIDTH+3, width of the power outputs (35).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a measurement when idle.
- cont  in  1  continuous mode; re-arm automatically after each block.
- in_valid  in  1  In_I/In_Q valid this cycle.
- In_I  in  DWIDTH  received I sample, signed.
- In_Q  in  DWIDTH  received Q sample, signed.
- busy  out  1  high from accepted start until the block result is issued.
- est_valid  out  1  one-cycle pulse; result outputs updated.
- noise_pow  out  POW_W  mean of e_I^2+e_Q^2 over the block, unsigned.
- sig_pow  out  POW_W  mean of I^2+Q^2 over the block, unsigned.
- sat_count  out  LOG2_N+1  full-scale samples in the block (see Optional Feature).

Behaviour:
- Reset (rst=0 at posedge) values:
  - All outputs 0.
  - FSM in IDLE.
  - Accumulators, sample counter and pipeline valids cleared.
  - Reset mid-block discards the block; no est_valid is issued.
- Slicer:
  - dI = +A_REF if In_I >= 0, else -A_REF; zero maps to +A_REF. Same rule for Q.
  - e = In - d, computed in DWIDTH+1 bits, never saturated.
- Pipeline (only in_valid samples advance):
  - S1 registers e_I, e_Q, In_I, In_Q.
  - S2 registers the squares, 2*DWIDTH+2 bits unsigned.
  - S3 adds I+Q and accumulates into accumulators of POW_W+LOG2_N bits. No overflow by construction.
- FSM states:
  - IDLE: start=1 → ACCUM, clear accumulators and counter, set busy=1. in_valid is ignored in IDLE.
  - ACCUM: count accepted samples. After the N-th sample → FLUSH. start is ignored.
  - FLUSH: wait for the pipeline to drain (2 cycles) → DONE.
  - DONE: outputs <= accumulator >> LOG2_N (truncating), est_valid=1 for exactly one cycle.
    - If cont=1: → ACCUM with accumulators cleared, busy stays 1.
    - Else: → IDLE, busy=0.
- Latency: est_valid is high in the cycle starting 4 posedges after the posedge that captured the N-th sample.
- Samples arriving in FLUSH or DONE are not counted and are dropped. This is documented; a cont-mode gap of 3 cycles is expected.
- in_valid gaps inside ACCUM are allowed and do not affect the result.
- Outputs hold their last value until the next DONE.

Optional Feature:
- Macro RX_NOISE_SATCOUNT_EN.
- When defined: sat_count counts samples in the block where In_I or In_Q equals +(2^(DWIDTH-1)-1) or -2^(DWIDTH-1). Each sample counts at most 1. Count range 0..N. Updated at DONE alongside the other outputs.
- When undefined: the port stays and is tied to 0; no counter logic is built.

Decomposition:
- Package rx_est_pkg holds:
  - FSM state encoding (IDLE, ACCUM, FLUSH, DONE).
  - Width helper constants: error width, square width, accumulator width.
- One natural sub-module, rx_err_power: the slicer, error and squaring pipeline S1–S2, instantiated once. The FSM and accumulators remain in the top.

Test Plan:
- Clean point: start, 64 samples of I=10000, Q=-10000 → noise_pow=0, sig_pow=200000000, est_valid exactly 4 cycles after the 64th sample.
- Fixed offset: 64 samples of I=10100, Q=-9900 → noise_pow=20000, sig_pow=200020000.
- Zero tie and extremes:
  - 64 samples of I=Q=0 → noise_pow=200000000, sig_pow=0.
  - 64 samples of I=Q=-32768 → noise_pow=1036763648, sig_pow=2147483648, sat_count=64 with RX_NOISE_SATCOUNT_EN, 0 without.
- Handshake:
  - in_valid toggled 1/0 during the block → results identical to the gapless run.
  - start pulsed mid-block → ignored, single est_valid.
  - cont=1 → back-to-back est_valid with busy held high.
- Reset mid-block: rst=0 after 30 samples → all outputs 0, busy=0, no est_valid. A fresh start then yields the correct clean-point result.
